serdes_rx_framer: RTL and testbench

Receive-side framer on the output of the SerDes FIFO: consumes the recovered parallel word stream (valid only, no backpressure), hunts for a sync word, parses a length-prefixed frame, streams payload words into an internal buffer towards a ready/valid consumer, and checks an XOR checksum. Frame status is reported as single-cycle pulses plus a sticky overflow flag.

---
 rtl/serdes_rx_framer.sv | 139 +++++++++++++
 tb/tb_serdes_rx_framer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serdes_rx_framer.sv
// Receive framer: hunts for SYNC_WORD, parses length-prefixed frames, buffers the
// payload towards a ready/valid consumer and checks an XOR checksum.
module serdes_rx_framer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter int                    MAX_LEN    = 16,
    parameter int                    FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  last_out,
    output logic                  frame_ok,
    output logic                  crc_err,
    output logic                  len_err,
    output logic                  overflow
);

    // state     | meaning
    // S_HUNT    | discard words until SYNC_WORD
    // S_LEN     | capture payload length
    // S_PAYLOAD | accumulate checksum, push payload words
    // S_CHECK   | compare checksum word, report status
    typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK} state_t;

    localparam int                    AW        = $clog2(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [DATA_WIDTH-1:0] ONE_W     = DATA_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  crc_err_q, crc_err_d;
    logic                  len_err_q, len_err_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  push, push_last, push_ok, pop;
    logic                  empty, full;
    logic [DATA_WIDTH:0]   head;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        push       = 1'b0;
        push_last  = 1'b0;
        frame_ok_d = 1'b0;
        crc_err_d  = 1'b0;
        len_err_d  = 1'b0;
        if (valid_in) begin
            unique case (state_q)
                S_HUNT: begin
                    if (parallel_in == SYNC_WORD) state_d = S_LEN;
                end
                S_LEN: begin
                    acc_d = '0;
                    if (parallel_in > MAX_LEN_W) begin
                        len_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end else if (parallel_in == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d   = parallel_in;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    acc_d     = acc_q ^ parallel_in;
                    push      = 1'b1;
                    push_last = (cnt_q == ONE_W);
                    cnt_d     = cnt_q - ONE_W;
                    if (cnt_q == ONE_W) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (parallel_in == acc_q) frame_ok_d = 1'b1;
                    else                      crc_err_d  = 1'b1;
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ready_in;
    // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
    assign push_ok    = push && (!full || pop);
    assign overflow_d = overflow_q || (push && full && !pop);
    assign wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d   = pop     ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            cnt_q      <= '0;
            acc_q      <= '0;
            frame_ok_q <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            frame_ok_q <= frame_ok_d;
            crc_err_q  <= crc_err_d;
            len_err_q  <= len_err_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {push_last, parallel_in};
    end

    // Storage is not cleared on reset; the head is masked while the buffer is empty.
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_out    = !empty;
    assign parallel_out = empty ? '0 : head[DATA_WIDTH-1:0];
    assign last_out     = !empty && head[DATA_WIDTH];
    assign frame_ok     = frame_ok_q;
    assign crc_err      = crc_err_q;
    assign len_err      = len_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_serdes_rx_framer.sv
// Directed bench for serdes_rx_framer: framing, hunt/gaps, length errors,
// backpressure/overflow, reset mid-frame and full-buffer push/pop.
module tb_serdes_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] parallel_in;
    logic       valid_in;
    logic [7:0] parallel_out;
    logic       valid_out;
    logic       ready_in;
    logic       last_out;
    logic       frame_ok;
    logic       crc_err;
    logic       len_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serdes_rx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .parallel_in  (parallel_in),
        .valid_in     (valid_in),
        .parallel_out (parallel_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .last_out     (last_out),
        .frame_ok     (frame_ok),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic [7:0] d, input logic v);
        @(negedge clk);
        parallel_in = d;
        valid_in    = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 16'(valid_out), 16'h1);
        chk({tag, "_data"},  16'(parallel_out), 16'(d));
        chk({tag, "_last"},  16'(last_out), 16'(l));
    endtask

    task automatic chk_status(input string tag, input logic ok, input logic ce, input logic le);
        chk({tag, "_frame_ok"}, 16'(frame_ok), 16'(ok));
        chk({tag, "_crc_err"},  16'(crc_err),  16'(ce));
        chk({tag, "_len_err"},  16'(len_err),  16'(le));
    endtask

    initial begin
        rst         = 1'b1;
        parallel_in = 8'h00;
        valid_in    = 1'b0;
        ready_in    = 1'b1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        rst = 1'b0;
        chk("rst_valid", 16'(valid_out), 16'h0);
        chk("rst_data", 16'(parallel_out), 16'h0);
        chk("rst_last", 16'(last_out), 16'h0);
        chk("rst_ovf", 16'(overflow), 16'h0);
        chk_status("rst", 1'b0, 1'b0, 1'b0);

        // Basic frame, checksum 11^22^44 = 77
        step(8'hA5, 1'b1);
        step(8'h03, 1'b1);
        step(8'h11, 1'b1);
        chk_out("b1_w0", 8'h11, 1'b0);
        step(8'h22, 1'b1);
        chk_out("b1_w1", 8'h22, 1'b0);
        step(8'h44, 1'b1);
        chk_out("b1_w2", 8'h44, 1'b1);
        chk_status("b1_pre", 1'b0, 1'b0, 1'b0);
        step(8'h77, 1'b1);
        chk("b1_drained", 16'(valid_out), 16'h0);
        chk_status("b1_chk", 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0);
        chk_status("b1_after", 1'b0, 1'b0, 1'b0);

        // Same frame with a bad checksum
        step(8'hA5, 1'b1);
        step(8'h03, 1'b1);
        step(8'h11, 1'b1);
        chk_out("b2_w0", 8'h11, 1'b0);
        step(8'h22, 1'b1);
        step(8'h44, 1'b1);
        chk_out("b2_w2", 8'h44, 1'b1);
        step(8'h76, 1'b1);
        chk_status("b2_chk", 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b0);
        chk_status("b2_after", 1'b0, 1'b0, 1'b0);

        // Hunt through junk with gaps, then a zero-length frame
        step(8'h00, 1'b1);
        step(8'hA5, 1'b0);
        step(8'hFF, 1'b1);
        step(8'h00, 1'b0);
        step(8'hA5, 1'b1);
        step(8'h00, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        chk_status("h_gap", 1'b0, 1'b0, 1'b0);
        chk("h_nopay", 16'(valid_out), 16'h0);
        step(8'h00, 1'b1);
        chk_status("h_chk", 1'b1, 1'b0, 1'b0);
        chk("h_nopay2", 16'(valid_out), 16'h0);
        step(8'h00, 1'b0);
        chk_status("h_after", 1'b0, 1'b0, 1'b0);

        // Length 17 rejected, then a good frame (0F^F0 = FF)
        step(8'hA5, 1'b1);
        step(8'h11, 1'b1);
        chk_status("le_pulse", 1'b0, 1'b0, 1'b1);
        step(8'hA5, 1'b1);
        chk_status("le_after", 1'b0, 1'b0, 1'b0);
        step(8'h02, 1'b1);
        step(8'h0F, 1'b1);
        chk_out("le_w0", 8'h0F, 1'b0);
        step(8'hF0, 1'b1);
        chk_out("le_w1", 8'hF0, 1'b1);
        step(8'hFF, 1'b1);
        chk_status("le_chk", 1'b1, 1'b0, 1'b0);

        // Backpressure: LEN = 16 fills the buffer, the next frame's payload is dropped
        ready_in = 1'b0;
        step(8'hA5, 1'b1);
        step(8'h10, 1'b1);
        for (int i = 1; i <= 16; i++) step(8'(i), 1'b1);
        chk_out("bp_hold0", 8'h01, 1'b0);
        step(8'h10, 1'b1);
        chk_status("bp_chk", 1'b1, 1'b0, 1'b0);
        chk("bp_ovf0", 16'(overflow), 16'h0);
        step(8'hA5, 1'b1);
        step(8'h02, 1'b1);
        step(8'h01, 1'b1);
        chk("bp_ovf1", 16'(overflow), 16'h1);
        chk_out("bp_hold1", 8'h01, 1'b0);
        step(8'h02, 1'b1);
        step(8'h03, 1'b1);
        chk_status("bp_chk2", 1'b1, 1'b0, 1'b0);
        ready_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk_out($sformatf("bp_drain%0d", i), 8'(i), (i == 16));
            step(8'h00, 1'b0);
        end
        chk("bp_empty", 16'(valid_out), 16'h0);
        chk("bp_ovf_sticky", 16'(overflow), 16'h1);

        // Reset in the middle of a frame
        step(8'hA5, 1'b1);
        step(8'h04, 1'b1);
        step(8'h10, 1'b1);
        chk_out("rm_w0", 8'h10, 1'b0);
        rst = 1'b1;
        step(8'h00, 1'b0);
        rst = 1'b0;
        chk("rm_valid", 16'(valid_out), 16'h0);
        chk("rm_data", 16'(parallel_out), 16'h0);
        chk("rm_last", 16'(last_out), 16'h0);
        chk("rm_ovf", 16'(overflow), 16'h0);
        chk_status("rm", 1'b0, 1'b0, 1'b0);
        step(8'hA5, 1'b1);
        step(8'h01, 1'b1);
        step(8'h5A, 1'b1);
        chk_out("rm_w1", 8'h5A, 1'b1);
        step(8'h5A, 1'b1);
        chk_status("rm_chk", 1'b1, 1'b0, 1'b0);
        chk("rm_empty", 16'(valid_out), 16'h0);

        // Full buffer with push and pop in the same cycle (20..2F XOR to 00)
        ready_in = 1'b0;
        step(8'hA5, 1'b1);
        step(8'h10, 1'b1);
        for (int i = 0; i < 16; i++) step(8'h20 + 8'(i), 1'b1);
        step(8'h00, 1'b1);
        chk_status("fp_chk", 1'b1, 1'b0, 1'b0);
        step(8'hA5, 1'b1);
        step(8'h01, 1'b1);
        ready_in = 1'b1;
        step(8'h5A, 1'b1);
        ready_in = 1'b0;
        chk("fp_ovf", 16'(overflow), 16'h0);
        chk_out("fp_head", 8'h21, 1'b0);
        step(8'h5A, 1'b1);
        chk_status("fp_chk2", 1'b1, 1'b0, 1'b0);
        ready_in = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk_out($sformatf("fp_drain%0d", i), 8'h20 + 8'(i), (i == 15));
            step(8'h00, 1'b0);
        end
        chk_out("fp_drain16", 8'h5A, 1'b1);
        step(8'h00, 1'b0);
        chk("fp_empty", 16'(valid_out), 16'h0);
        chk("fp_ovf_end", 16'(overflow), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
